// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch engine (valid/ready request, valid response bus, held word to IF/ID).
// Optional FETCH_CTRL_MISALIGN_CHECK_EN faults misaligned redirect targets without a bus request.
module fetch_ctrl #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ctrl_inst_valid_i,
    input  logic            fetch_ctrl_dont_fetch_i,
    input  logic            fetch_ctrl_if_flush_i,
    input  logic            fetch_ctrl_redirect_i,
    input  logic [XLEN-1:0] fetch_ctrl_redirect_pc_i,
    output logic            fetch_ctrl_req_valid_o,
    input  logic            fetch_ctrl_req_ready_i,
    output logic [XLEN-1:0] fetch_ctrl_req_addr_o,
    input  logic            fetch_ctrl_rsp_valid_i,
    input  logic [31:0]     fetch_ctrl_rsp_data_i,
    input  logic            fetch_ctrl_rsp_err_i,
    output logic            fetch_ctrl_fetched_ok_o,
    output logic [XLEN-1:0] fetch_ctrl_pc_o,
    output logic [31:0]     fetch_ctrl_inst_o,
    output logic            fetch_ctrl_inst_nop_o,
    output logic            fetch_ctrl_fault_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst_r;
    logic            fault;
    logic            advance;
    logic            misalign;

    assign advance = state == S_HOLD && fetch_ctrl_inst_valid_i;

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
    assign misalign = fetch_ctrl_redirect_i && |fetch_ctrl_redirect_pc_i[1:0];
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state <= !rst_n ? S_IDLE : state_nx;
    end

    always_comb begin
        state_nx = state == S_IDLE ? S_REQ :
                   state == S_REQ  ? (fetch_ctrl_req_ready_i ? S_WAIT : S_REQ) :
                   state == S_WAIT ? (fetch_ctrl_rsp_valid_i ? S_HOLD : S_WAIT) :
                   !fetch_ctrl_inst_valid_i || misalign ||
                   (!fetch_ctrl_redirect_i && fetch_ctrl_dont_fetch_i) ? S_HOLD : S_REQ;
    end

    // redirect beats dont_fetch; a faulted misaligned target skips the bus entirely
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            inst_r <= NOP_INST;
            fault  <= 1'b0;
        end else if (state == S_WAIT && fetch_ctrl_rsp_valid_i) begin
            inst_r <= fetch_ctrl_rsp_err_i ? NOP_INST : fetch_ctrl_rsp_data_i;
            fault  <= fetch_ctrl_rsp_err_i;
        end else if (advance && fetch_ctrl_redirect_i) begin
            pc     <= fetch_ctrl_redirect_pc_i;
            inst_r <= NOP_INST;
            fault  <= misalign;
        end else if (advance && !fetch_ctrl_dont_fetch_i) begin
            pc     <= pc + XLEN'(4);
            fault  <= 1'b0;
        end
    end

    always_comb begin
        fetch_ctrl_req_valid_o  = state == S_REQ;
        fetch_ctrl_fetched_ok_o = state == S_HOLD;
        fetch_ctrl_inst_nop_o   = !fetch_ctrl_fetched_ok_o || fetch_ctrl_if_flush_i || fault;
        fetch_ctrl_inst_o       = fetch_ctrl_inst_nop_o ? NOP_INST : inst_r;
        fetch_ctrl_req_addr_o   = pc;
        fetch_ctrl_pc_o         = pc;
        fetch_ctrl_fault_o      = fault;
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench with a bus responder and a scoreboard of expected held words.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 0;
    logic        rst_n, inst_valid, dont_fetch, if_flush, redirect;
    logic [63:0] redirect_pc;
    logic        req_valid, req_ready, rsp_valid, rsp_err;
    logic [63:0] req_addr, pc_o;
    logic [31:0] rsp_data, inst_o;
    logic        fetched_ok, inst_nop, fault;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_pc;
    logic [31:0] last_inst;

    fetch_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_ctrl_inst_valid_i(inst_valid),
        .fetch_ctrl_dont_fetch_i(dont_fetch),
        .fetch_ctrl_if_flush_i(if_flush),
        .fetch_ctrl_redirect_i(redirect),
        .fetch_ctrl_redirect_pc_i(redirect_pc),
        .fetch_ctrl_req_valid_o(req_valid),
        .fetch_ctrl_req_ready_i(req_ready),
        .fetch_ctrl_req_addr_o(req_addr),
        .fetch_ctrl_rsp_valid_i(rsp_valid),
        .fetch_ctrl_rsp_data_i(rsp_data),
        .fetch_ctrl_rsp_err_i(rsp_err),
        .fetch_ctrl_fetched_ok_o(fetched_ok),
        .fetch_ctrl_pc_o(pc_o),
        .fetch_ctrl_inst_o(inst_o),
        .fetch_ctrl_inst_nop_o(inst_nop),
        .fetch_ctrl_fault_o(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_valid", req_valid, 0);
        chk("rst_fetched_ok", fetched_ok, 0);
        chk("rst_inst_nop", inst_nop, 1);
        chk("rst_fault", fault, 0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_pc", pc_o, RST_PC);
    endtask

    // wait for the request, stall it dly cycles, answer next cycle, then compare the held word
    task automatic serve(input int dly, input logic err);
        int   n = 0;
        exp_t e;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", req_valid, 1);
        if (!req_valid) return;
        chk("req_addr", req_addr, exp_pc);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("req_stall_valid", req_valid, 1);
            chk("req_stall_addr", req_addr, exp_pc);
        end
        req_ready = 1;
        sb.push_back('{exp_pc, err ? NOP : mem(exp_pc), err});
        tick();
        req_ready = 0;
        chk("wait_not_ok", fetched_ok, 0);
        rsp_valid = 1;
        rsp_data  = mem(exp_pc);
        rsp_err   = err;
        tick();
        rsp_valid = 0;
        rsp_err   = 0;
        e = sb.pop_front();
        chk("hold_ok", fetched_ok, 1);
        chk("hold_pc", pc_o, e.pc);
        chk("hold_inst", inst_o, e.inst);
        chk("hold_fault", fault, e.fault);
        chk("hold_nop", inst_nop, e.fault);
        last_inst = e.inst;
    endtask

    task automatic advance(input logic rd, input logic [63:0] rpc, input logic df);
        inst_valid  = 1;
        redirect    = rd;
        redirect_pc = rpc;
        dont_fetch  = df;
        tick();
        inst_valid  = 0;
        redirect    = 0;
        dont_fetch  = 0;
    endtask

    initial begin
        rst_n = 0; inst_valid = 0; dont_fetch = 0; if_flush = 0; redirect = 0;
        redirect_pc = 0; req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0;
        last_inst = NOP;
        // 1: reset, first fetch at RESET_PC with a zero-wait bus
        repeat (3) tick();
        chk_reset_outputs();
        rst_n = 1;
        chk("idle_no_req", req_valid, 0);
        tick();
        chk("cycle1_req", req_valid, 1);
        exp_pc = RST_PC;
        serve(0, 0);
        // rsp_valid outside WAIT must not disturb the held word
        rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; rsp_err = 1;
        tick();
        rsp_valid = 0; rsp_err = 0;
        chk("stray_rsp_inst", inst_o, last_inst);
        chk("stray_rsp_fault", fault, 0);
        chk("stray_rsp_ok", fetched_ok, 1);
        // 2: plain advance
        advance(0, 0, 0);
        chk("adv_nop", inst_nop, 1);
        chk("adv_not_ok", fetched_ok, 0);
        exp_pc = exp_pc + 4;
        serve(0, 0);
        // 3: four dont_fetch advances re-present the same word
        for (int i = 0; i < 4; i++) begin
            advance(0, 0, 1);
            chk("df_ok", fetched_ok, 1);
            chk("df_req", req_valid, 0);
            chk("df_pc", pc_o, exp_pc);
            chk("df_inst", inst_o, last_inst);
        end
        // 4: redirect with flush bubbles the current output
        inst_valid = 1; redirect = 1; if_flush = 1; redirect_pc = 64'h8000_1000;
        #1;
        chk("flush_inst", inst_o, NOP);
        chk("flush_nop", inst_nop, 1);
        tick();
        inst_valid = 0; redirect = 0; if_flush = 0;
        exp_pc = 64'h8000_1000;
        serve(0, 0);
        // 5: stalled request and bus error
        advance(0, 0, 0);
        exp_pc = exp_pc + 4;
        serve(5, 1);
        advance(0, 0, 0);
        chk("fault_cleared", fault, 0);
        exp_pc = exp_pc + 4;
        serve(2, 0);
        // redirect wins over dont_fetch; pc wraps at 2^64
        advance(1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        chk("rd_prio_req", req_valid, 1);
        exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        serve(0, 0);
        advance(0, 0, 0);
        exp_pc = 64'h0;
        serve(0, 0);
        // 6: misaligned redirect
        advance(1, 64'h8000_0002, 0);
        exp_pc = 64'h8000_0002;
`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
        chk("mis_req", req_valid, 0);
        chk("mis_ok", fetched_ok, 1);
        chk("mis_fault", fault, 1);
        chk("mis_pc", pc_o, exp_pc);
        chk("mis_nop", inst_nop, 1);
        chk("mis_inst", inst_o, NOP);
`else
        serve(0, 0);
`endif
        // reset while a request is outstanding
        advance(0, 0, 0);
        req_ready = 1;
        tick();
        req_ready = 0;
        rst_n = 0;
        tick();
        chk_reset_outputs();
        rst_n = 1;
        tick();
        exp_pc = RST_PC;
        serve(0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
